// File: rtl/ca_pkg.sv
// rtl/ca_pkg.sv - shared constants and fetch entry type for the fetch stage
package ca_pkg;

    localparam int                 INSTR_W    = 32;
    localparam int                ADDR_W_DEF = 32;
    localparam int                PC_STEP    = 4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0]    instr;
        logic [ADDR_W_DEF-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - synchronous FIFO with flush, used for the prefetch buffer and the PC queue
module if_fifo
    import ca_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    input  logic          flush,
    output T              head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // flush wins over a simultaneous push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - PC sequencing, imem request/response and prefetch FIFO to decode
// Optional perf counters enabled by defining IF_PERF_CNT_EN.
module instr_fetch_stage
    import ca_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 4,
    parameter int                MAX_OUTST  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0] dec_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_flush
`endif
);

    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int SW  = CW + 1;
    localparam int QCW = $clog2(MAX_OUTST + 1);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [CW-1:0]     r_outst;
    logic [CW-1:0]     r_drop;
    logic [CW-1:0]     w_outst_nxt;
    logic [CW-1:0]     w_fifo_cnt;
    logic [QCW-1:0]    w_pcq_cnt;
    logic [ADDR_W-1:0] w_pcq_head;
    logic              w_pcq_full;
    logic              w_pcq_empty;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_accept;
    logic              w_rsp_ok;
    logic              w_drop;
    logic              w_push;
    logic              w_pop;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;

    // Budget counts in-flight requests against FIFO space so every response has a slot.
    assign imem_req_valid = rst_n && !redirect_valid
                         && (SW'(r_outst) + SW'(w_fifo_cnt) < SW'(FIFO_DEPTH))
                         && (r_outst < CW'(MAX_OUTST));
    assign imem_req_addr  = r_fetch_pc;

    assign w_accept    = imem_req_valid && imem_req_ready;
    assign w_rsp_ok    = imem_rsp_valid && (r_outst != '0);
    assign w_drop      = w_rsp_ok && (redirect_valid || (r_drop != '0));
    assign w_push      = w_rsp_ok && !w_drop;
    assign w_pop       = dec_valid && dec_ready;
    assign w_outst_nxt = r_outst + CW'(w_accept) - CW'(w_rsp_ok);

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.instr = imem_rsp_data;
        w_push_entry.pc    = ADDR_W_DEF'(w_pcq_head);
    end

    // PC queue only holds live requests; stale ones are flushed and covered by r_drop.
    if_fifo #(
        .DEPTH (MAX_OUTST),
        .T     (logic [ADDR_W-1:0])
    ) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_accept),
        .push_data (r_fetch_pc),
        .pop       (w_push),
        .flush     (redirect_valid),
        .head      (w_pcq_head),
        .full      (w_pcq_full),
        .empty     (w_pcq_empty),
        .count     (w_pcq_cnt)
    );

    if_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_prefetch (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_cnt)
    );

    assign dec_valid = !w_fifo_empty;
    assign dec_instr = dec_valid ? w_head.instr : NOP_INSTR;
    assign dec_pc    = dec_valid ? ADDR_W'(w_head.pc) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc & ~ADDR_W'(3);
                r_drop     <= w_outst_nxt;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
                end
                if (w_rsp_ok && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
            r_perf_flush   <= '0;
        end else begin
            if (w_pop && (r_perf_fetched != '1)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (dec_ready && !dec_valid && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (redirect_valid && (r_perf_flush != '1)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
    assign perf_flush   = r_perf_flush;
`endif

    a_rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (r_outst == '0)));
    a_pcq_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_accept && w_pcq_full));
    a_pcq_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && w_pcq_empty));
    a_pcq_tracks: assert property (@(posedge clk) disable iff (!rst_n)
        SW'(w_pcq_cnt) <= SW'(r_outst));
    a_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - directed and random checks of instr_fetch_stage against a sequential-stream model
module tb_instr_fetch_stage;
    import ca_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          n_pop = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    logic [31:0] exp_pc = RPC;
    logic [31:0] salt;
    logic [31:0] last_pop_pc = '0;
    logic [31:0] mq_addr [$];
    int          mq_due [$];
    logic        obs_dv;
    logic        obs_rv;
    logic [31:0] obs_addr;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;

    always #5 clk = ~clk;

    instr_fetch_stage #(
        .ADDR_W     (32),
        .RESET_PC   (RPC),
        .FIFO_DEPTH (4),
        .MAX_OUTST  (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
        .perf_flush     (perf_flush)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        chk({tag, "_req_addr"}, imem_req_addr, RPC);
        chk({tag, "_dec_valid"}, {31'b0, dec_valid}, 32'd0);
        chk({tag, "_dec_instr"}, dec_instr, 32'd0);
        chk({tag, "_dec_pc"}, dec_pc, 32'd0);
    endtask

    // One clock cycle: drive at the falling edge, observe 1 time unit later, return at the next falling edge.
    task automatic cycle(input logic rdy_dec, input logic rdy_req, input logic redir, input logic [31:0] rpc);
        dec_ready      = rdy_dec;
        imem_req_ready = rdy_req;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (rst_n && mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        obs_dv   = dec_valid;
        obs_rv   = imem_req_valid;
        obs_addr = imem_req_addr;
        if (prev_hold && !redir) begin
            chk("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("req_hold_addr", imem_req_addr, prev_addr);
        end
        prev_hold = imem_req_valid && !imem_req_ready;
        prev_addr = imem_req_addr;
        if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + 1 + int'($urandom_range(lat_max, lat_min)));
        end
        if (dec_valid && dec_ready) begin
            chk("dec_pc", dec_pc, exp_pc);
            chk("dec_instr", dec_instr, mem_word(exp_pc));
            last_pop_pc = dec_pc;
            exp_pc      = exp_pc + 32'd4;
            n_pop++;
        end
        if (redir) begin
            exp_pc = rpc & 32'hFFFF_FFFC;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_pop(input string tag, input int bound);
        int start;
        int i;
        start = n_pop;
        i     = 0;
        while (n_pop == start && i < bound) begin
            cycle(1'b1, 1'b1, 1'b0, 32'd0);
            i++;
        end
        chk(tag, {31'b0, n_pop != start}, 32'd1);
    endtask

    initial begin
        int          p0;
        logic [31:0] e0;
        logic [31:0] a0;

        salt = $urandom;
        @(negedge clk);
        #1;
        chk_reset_outputs("rst0");
        @(negedge clk);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        rst_n = 1'b1;

        // Start-up latency and sequential stream
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("lat_c0_dv", {31'b0, obs_dv}, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("lat_c1_dv", {31'b0, obs_dv}, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("lat_c2_dv", {31'b0, obs_dv}, 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("seq_pops", n_pop, 32'd4);
        chk("seq_last_pc", last_pop_pc, 32'h0000_000C);

        // Decode backpressure fills the FIFO, then drain with memory stalled
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
        chk("bp_req_valid", {31'b0, obs_rv}, 32'd0);
        chk("bp_dec_valid", {31'b0, obs_dv}, 32'd1);
        p0 = n_pop;
        e0 = exp_pc;
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        a0 = obs_addr;
        chk("stall_addr_next", a0, e0 + 32'd16);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        chk("stall_addr_same", obs_addr, a0);
        chk("stall_req_valid", {31'b0, obs_rv}, 32'd1);
        chk("drain_count", n_pop - p0, 32'd4);
        chk("drain_dec_valid", {31'b0, obs_dv}, 32'd0);

        // Redirect with two requests in flight
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("redir_inflight", mq_addr.size(), 32'd2);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        chk("redir_req_valid", {31'b0, obs_rv}, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("redir_dec_valid", {31'b0, obs_dv}, 32'd0);
        wait_pop("redir_wait", 40);
        chk("redir_first_pc", last_pop_pc, 32'h0000_0100);
        lat_min = 0;
        lat_max = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Redirect, pop and response in the same cycle
        p0 = n_pop;
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        chk("rp_dec_valid", {31'b0, obs_dv}, 32'd1);
        chk("rp_rsp_valid", {31'b0, imem_rsp_valid}, 32'd1);
        chk("rp_pop", n_pop - p0, 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("rp_next_dv", {31'b0, obs_dv}, 32'd0);
        wait_pop("rp_wait", 20);
        chk("rp_first_pc", last_pop_pc, 32'h0000_0200);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Reset with requests in flight
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("rst_inflight", mq_addr.size(), 32'd2);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        mq_addr.delete();
        mq_due.delete();
        prev_hold = 1'b0;
        exp_pc    = RPC;
        lat_min   = 0;
        lat_max   = 0;
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        rst_n = 1'b1;
        wait_pop("rst_wait", 20);
        chk("rst_first_pc", last_pop_pc, RPC);

        // Random traffic, latency and redirects
        lat_min = 0;
        lat_max = 3;
        p0 = n_pop;
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
                  $urandom_range(39, 0) == 0, $urandom);
        end
        chk("rand_progress", {31'b0, (n_pop - p0) > 200}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
